sha256_compress_core: RTL and testbench

Iterative SHA-256 compression engine. It accepts one 512-bit message block plus a 256-bit chaining value, runs 64 rounds at a configurable number of rounds per clock, and returns the fed-forward 256-bit digest. It sits between the miner's block/nonce feeder and the double-hash sequencer; the same core is used for both the midstate hash and the second hash. UNROLL trades area for latency.

---
 rtl/sha256_pkg.sv | 93 +++++++++
 rtl/sha256_round.sv | 28 ++
 rtl/sha256_compress_core.sv | 129 ++++++++++++
 tb/tb_sha256_compress_core.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, working-variable struct, FSM state type and
// the bitwise round helper functions used by the compression core.
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Field order puts a (H0) in the top 32 bits of the packed 256-bit view.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } wv_t;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        logic [63:0] xx;
        xx = {x, x} >> n;
        return xx[31:0];
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] sig_ch(input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] sig_maj(input logic [31:0] x, input logic [31:0] y,
                                            input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Feed-forward: per-word add mod 2^32.
    function automatic wv_t wv_add(input wv_t x, input wv_t y);
        wv_t r;
        r.a = x.a + y.a;
        r.b = x.b + y.b;
        r.c = x.c + y.c;
        r.d = x.d + y.d;
        r.e = x.e + y.e;
        r.f = x.f + y.f;
        r.g = x.g + y.g;
        r.h = x.h + y.h;
        return r;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: working variables, K[t] and W[t] in,
// updated working variables out.
module sha256_round
    import sha256_pkg::*;
(
    input  wv_t         s_in,
    input  logic [31:0] k,
    input  logic [31:0] w,
    output wv_t         s_out
);

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1 = s_in.h + bsig1(s_in.e) + sig_ch(s_in.e, s_in.f, s_in.g) + k + w;
        t2 = bsig0(s_in.a) + sig_maj(s_in.a, s_in.b, s_in.c);
        s_out.a = t1 + t2;
        s_out.b = s_in.a;
        s_out.c = s_in.b;
        s_out.d = s_in.c;
        s_out.e = s_in.d + t1;
        s_out.f = s_in.e;
        s_out.g = s_in.f;
        s_out.h = s_in.g;
    end

endmodule

// File: rtl/sha256_compress_core.sv
// Iterative SHA-256 compression: UNROLL chained rounds per clock over a
// 16-word rolling message-schedule window, with chaining-value feed-forward.
module sha256_compress_core
    import sha256_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] chain_in,
    input  logic [511:0] block_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] digest_out,
    output logic         busy
);

    if (UNROLL < 1 || UNROLL > 64 || (64 % UNROLL) != 0) begin : g_bad_unroll
        $error("sha256_compress_core: UNROLL=%0d must divide 64", UNROLL);
    end

    localparam logic [5:0] RND_LAST = 6'(64 - UNROLL);
    localparam logic [5:0] RND_STEP = 6'(UNROLL);

    state_t             state_q, state_d;
    wv_t                hin_q, hin_d;
    wv_t                work_q, work_d;
    wv_t                digest_q, digest_d;
    logic [15:0][31:0]  w_q, w_d;
    logic [15:0][31:0]  w_next;
    logic [5:0]         rnd_q, rnd_d;
    wv_t                st_last;

    // Extended schedule: slots 0..15 are the stored window, later slots are
    // derived on the fly so each cycle can consume UNROLL words.
    for (genvar i = 0; i < UNROLL + 16; i++) begin : g_w
        logic [31:0] wt;
        if (i < 16) begin : g_ld
            assign wt = w_q[i];
        end else begin : g_sc
            assign wt = ssig1(g_w[i-2].wt) + g_w[i-7].wt + ssig0(g_w[i-15].wt) + g_w[i-16].wt;
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_wnext
        assign w_next[i] = g_w[i+UNROLL].wt;
    end

    for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
        wv_t si;
        wv_t so;
        if (j == 0) begin : g_first
            assign si = work_q;
        end else begin : g_chain
            assign si = g_rnd[j-1].so;
        end
        sha256_round u_round (
            .s_in  (si),
            .k     (K[rnd_q + 6'(j)]),
            .w     (g_w[j].wt),
            .s_out (so)
        );
    end

    assign st_last = g_rnd[UNROLL-1].so;

    always_comb begin
        state_d  = state_q;
        hin_d    = hin_q;
        work_d   = work_q;
        digest_d = digest_q;
        w_d      = w_q;
        rnd_d    = rnd_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    hin_d  = chain_in;
                    work_d = chain_in;
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = block_in[511 - 32*i -: 32];
                    end
                    rnd_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d = st_last;
                w_d    = w_next;
                rnd_d  = rnd_q + RND_STEP;
                if (rnd_q == RND_LAST) begin
                    digest_d = wv_add(hin_q, st_last);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hin_q    <= '0;
            work_q   <= '0;
            digest_q <= '0;
            w_q      <= '0;
            rnd_q    <= '0;
        end else begin
            state_q  <= state_d;
            hin_q    <= hin_d;
            work_q   <= work_d;
            digest_q <= digest_d;
            w_q      <= w_d;
            rnd_q    <= rnd_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign digest_out = digest_q;

endmodule

// File: tb/tb_sha256_compress_core.sv
// Directed bench for sha256_compress_core at UNROLL 1, 4 and 64 using
// known FIPS 180 digests for "abc", "" and the two-block 448-bit message.
module tb_sha256_compress_core;
    import sha256_pkg::*;

    localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B_TWO1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};

    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk;
    logic         rst_n;
    logic         in_valid   [3];
    logic         in_ready   [3];
    logic [255:0] chain_in   [3];
    logic [511:0] block_in   [3];
    logic         out_valid  [3];
    logic         out_ready  [3];
    logic [255:0] digest_out [3];
    logic         busy       [3];

    int checks = 0;
    int errors = 0;

    // Instance 0: UNROLL=1, instance 1: UNROLL=4, instance 2: UNROLL=64.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        sha256_compress_core #(.UNROLL(g == 0 ? 1 : (g == 1 ? 4 : 64))) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .chain_in   (chain_in[g]),
            .block_in   (block_in[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .digest_out (digest_out[g]),
            .busy       (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Called at posedge+1 on the accept edge's following cycle; counts edges to out_valid.
    task automatic wait_out(input int k, output int lat, output logic [255:0] dig);
        lat = 0;
        while (out_valid[k] !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        dig = digest_out[k];
    endtask

    // Called at posedge+1 with the instance idle.
    task automatic send(input int k, input logic [255:0] ch, input logic [511:0] blk,
                        output int lat, output logic [255:0] dig);
        in_valid[k] = 1'b1;
        chain_in[k] = ch;
        block_in[k] = blk;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        wait_out(k, lat, dig);
    endtask

    typedef struct {
        int           k;
        logic [255:0] ch;
        logic [511:0] blk;
        logic [255:0] dig;
        int           lat;
    } vec_t;

    vec_t vt [5];

    initial begin
        int           lat;
        logic [255:0] dig;
        logic [255:0] d1;
        int           acc [$];
        int           viol;
        logic         prev_ov;

        vt[0] = '{k: 0, ch: IV, blk: B_ABC,   dig: D_ABC,   lat: 64};
        vt[1] = '{k: 1, ch: IV, blk: B_EMPTY, dig: D_EMPTY, lat: 16};
        vt[2] = '{k: 2, ch: IV, blk: B_EMPTY, dig: D_EMPTY, lat: 1};
        vt[3] = '{k: 1, ch: IV, blk: B_ABC,   dig: D_ABC,   lat: 16};
        vt[4] = '{k: 2, ch: IV, blk: B_ABC,   dig: D_ABC,   lat: 1};

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            chain_in[k]  = '0;
            block_in[k]  = '0;
            out_ready[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chki("reset_in_ready", int'(in_ready[k]), 1);
            chki("reset_out_valid", int'(out_valid[k]), 0);
            chki("reset_busy", int'(busy[k]), 0);
            chk("reset_digest", digest_out[k], '0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            send(vt[v].k, vt[v].ch, vt[v].blk, lat, dig);
            chk("tbl_digest", dig, vt[v].dig);
            chki("tbl_latency", lat, vt[v].lat);
            @(posedge clk); #1;
            chki("tbl_pulse", int'(out_valid[vt[v].k]), 0);
            chki("tbl_ready_back", int'(in_ready[vt[v].k]), 1);
        end

        // Two-block message, second block chained from the first digest.
        send(0, IV, B_TWO1, lat, d1);
        chki("two_blk1_latency", lat, 64);
        @(posedge clk); #1;
        send(0, d1, B_TWO2, lat, dig);
        chk("two_blk_digest", dig, D_TWO);
        @(posedge clk); #1;

        // Back-to-back with out_ready tied high at UNROLL=4.
        chain_in[1] = IV;
        block_in[1] = B_EMPTY;
        in_valid[1] = 1'b1;
        prev_ov = 1'b0;
        viol = 0;
        for (int c = 0; c < 80; c++) begin
            if (in_ready[1]) acc.push_back(c);
            if (out_valid[1]) begin
                chk("b2b_digest", digest_out[1], D_EMPTY);
                if (prev_ov) viol++;
            end
            prev_ov = out_valid[1];
            @(posedge clk); #1;
        end
        in_valid[1] = 1'b0;
        chki("b2b_accept_count", int'(acc.size() >= 4), 1);
        for (int i = 0; i < 3; i++) begin
            if (acc.size() > i + 1) chki("b2b_interval", acc[i+1] - acc[i], 18);
        end
        chki("b2b_pulse_width", viol, 0);
        repeat (20) @(posedge clk);
        #1;

        // Backpressure in DONE with in_valid toggling.
        out_ready[0] = 1'b0;
        send(0, IV, B_ABC, lat, dig);
        chki("bp_latency", lat, 64);
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = (i % 2 == 0);
            chain_in[0] = IV;
            block_in[0] = B_EMPTY;
            @(posedge clk); #1;
            chk("bp_digest_stable", digest_out[0], D_ABC);
            chki("bp_in_ready", int'(in_ready[0]), 0);
            chki("bp_out_valid", int'(out_valid[0]), 1);
        end
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        @(posedge clk); #1;
        chki("bp_release_out_valid", int'(out_valid[0]), 0);
        chki("bp_release_in_ready", int'(in_ready[0]), 1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        chki("bp_new_busy", int'(busy[0]), 1);
        wait_out(0, lat, dig);
        chki("bp_new_latency", lat, 64);
        chk("bp_new_digest", dig, D_EMPTY);
        @(posedge clk); #1;

        // Reset in the middle of a run.
        in_valid[0] = 1'b1;
        chain_in[0] = IV;
        block_in[0] = B_ABC;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chki("midrun_busy_before", int'(busy[0]), 1);
        rst_n = 1'b0;
        #1;
        chki("midrun_rst_out_valid", int'(out_valid[0]), 0);
        chki("midrun_rst_in_ready", int'(in_ready[0]), 1);
        chki("midrun_rst_busy", int'(busy[0]), 0);
        chk("midrun_rst_digest", digest_out[0], '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(0, IV, B_ABC, lat, dig);
        chki("post_rst_latency", lat, 64);
        chk("post_rst_digest", dig, D_ABC);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
